uart_tx_serializer: RTL



---
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word as start/data/[parity]/stop bits on a serial line.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              data_outbit
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  if ((DATA_W < 5) || (DATA_W > 9) || (CLKS_PER_BIT < 2) || (STOP_BITS < 1) ||
      (STOP_BITS > 2) || (LSB_FIRST > 1) || (PARITY_ODD > 1)) begin : g_bad_cfg
    $error("uart_tx_serializer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_baud_wrap;
  logic              w_out_bit;
  logic              w_line_nxt;
  logic              w_ready_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              r_line;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_baud_wrap = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (load) w_state_nxt = S_START;
      S_START: if (w_baud_wrap) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_baud_wrap && (r_bit_cnt == CNT_W'(DATA_W - 1))) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_baud_wrap) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (w_baud_wrap && (r_bit_cnt == CNT_W'(STOP_BITS - 1))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift toward the output end at each data-bit boundary, zero fill
  always_comb begin
    w_shift_nxt = r_shift;
    if ((r_state == S_DATA) && w_baud_wrap) begin
      if (LSB_FIRST != 0) w_shift_nxt = r_shift >> 1;
      else                w_shift_nxt = r_shift << 1;
    end
    w_out_bit = (LSB_FIRST != 0) ? w_shift_nxt[0] : w_shift_nxt[DATA_W-1];
  end

  // Output decode from the next state so outputs change on the same edge as the state
  always_comb begin
    w_line_nxt  = 1'b1;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = (r_state == S_STOP);
      end
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = w_out_bit;
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_line_nxt = r_parity;
`endif
      default:  w_line_nxt = 1'b1;
    endcase
  end

  // Counters, shift register and captured parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
      if (load) begin
        r_shift  <= datain;
`ifdef UART_TX_PARITY_EN
        r_parity <= (^datain) ^ 1'(PARITY_ODD);
`endif
      end
    end else begin
      r_baud  <= w_baud_wrap ? '0 : r_baud + BAUD_W'(1);
      r_shift <= w_shift_nxt;
      if (w_state_nxt != r_state) r_bit_cnt <= '0;
      else if (w_baud_wrap)       r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line  <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_line  <= w_line_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign data_outbit = r_line;
  assign ready       = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
